// File: rtl/energy_calc_ctrl.sv
// Ising-model energy calculator controller: streams weight rows from an external
// memory, accumulates the signed Hamiltonian and hands it off with valid/ready.
module energy_calc_ctrl #(
  parameter int NUM_SPIN      = 256,
  parameter int BITJ          = 4,
  parameter int BITH          = 4,
  parameter int SCALING_BIT   = 4,
  parameter int LITTLE_ENDIAN = 1,
  parameter int H_IS_NEGATIVE = 1,
  parameter int ENERGY_W      = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_valid_i,
  output logic                          start_ready_o,
  input  logic [NUM_SPIN-1:0]           spin_i,
  input  logic [NUM_SPIN*BITH-1:0]      hbias_i,
  input  logic [SCALING_BIT-1:0]        hscaling_i,
  output logic                          w_ren_o,
  output logic [$clog2(NUM_SPIN)-1:0]   w_raddr_o,
  input  logic [NUM_SPIN*BITJ-1:0]      w_rdata_i,
  output logic                          energy_valid_o,
  input  logic                          energy_ready_i,
  output logic [ENERGY_W-1:0]           energy_o,
  output logic                          busy_o
);

  localparam int AW = $clog2(NUM_SPIN);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_SPIN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                       state_q;
  logic [NUM_SPIN-1:0]          spin_q;
  logic [NUM_SPIN*BITH-1:0]     hbias_q;
  logic [SCALING_BIT-1:0]       hscale_q;
  logic                         start_ready_q;
  logic                         w_ren_q;
  logic [AW-1:0]                w_raddr_q;
  logic                         acc_en_q;
  logic [AW-1:0]                acc_idx_q;
  logic signed [ENERGY_W-1:0]   acc_q;
  logic signed [ENERGY_W-1:0]   acc_d;
  logic signed [ENERGY_W-1:0]   energy_q;
  logic signed [ENERGY_W-1:0]   energy_d;
  logic                         energy_valid_q;
  logic                         busy_q;

  // Column terms always use the raw spin order, independent of LITTLE_ENDIAN.
  logic signed [ENERGY_W-1:0] col_term [NUM_SPIN];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPIN; gi++) begin : g_col
      logic signed [BITJ-1:0] w_ij;
      assign w_ij         = w_rdata_i[gi*BITJ +: BITJ];
      assign col_term[gi] = spin_q[gi] ? ENERGY_W'(w_ij) : -ENERGY_W'(w_ij);
    end
  endgenerate

  logic [AW-1:0]              row_sel;
  logic                       row_spin;
  logic signed [BITH-1:0]     row_h;
  logic signed [SCALING_BIT:0] scale_s;
  logic signed [ENERGY_W-1:0] row_sum;
  logic signed [ENERGY_W-1:0] row_contrib;

  assign row_sel  = (LITTLE_ENDIAN != 0) ? acc_idx_q : (LAST_ADDR - acc_idx_q);
  assign row_spin = spin_q[row_sel];
  assign row_h    = hbias_q[row_sel*BITH +: BITH];
  assign scale_s  = {1'b0, hscale_q};

  always_comb begin
    row_sum = ENERGY_W'(row_h) * ENERGY_W'(scale_s);
    for (int j = 0; j < NUM_SPIN; j++) begin
      row_sum = row_sum + col_term[j];
    end
    row_contrib = row_spin ? row_sum : -row_sum;
    acc_d       = acc_en_q ? (acc_q + row_contrib) : acc_q;
    energy_d    = (H_IS_NEGATIVE != 0) ? -acc_d : acc_d;
  end

  // Row data arrives one cycle after its address, so the accumulate stage
  // tracks the read stage through acc_en_q/acc_idx_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      spin_q         <= '0;
      hbias_q        <= '0;
      hscale_q       <= '0;
      start_ready_q  <= 1'b1;
      w_ren_q        <= 1'b0;
      w_raddr_q      <= '0;
      acc_en_q       <= 1'b0;
      acc_idx_q      <= '0;
      acc_q          <= '0;
      energy_q       <= '0;
      energy_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      acc_en_q  <= w_ren_q;
      acc_idx_q <= w_raddr_q;
      acc_q     <= acc_d;
      case (state_q)
        S_IDLE: begin
          if (start_valid_i && start_ready_q) begin
            spin_q        <= spin_i;
            hbias_q       <= hbias_i;
            hscale_q      <= hscaling_i;
            acc_q         <= '0;
            start_ready_q <= 1'b0;
            w_ren_q       <= 1'b1;
            w_raddr_q     <= '0;
            busy_q        <= 1'b1;
            state_q       <= S_READ;
          end
        end
        S_READ: begin
          if (w_raddr_q == LAST_ADDR) begin
            w_ren_q   <= 1'b0;
            w_raddr_q <= '0;
            state_q   <= S_DRAIN;
          end else begin
            w_raddr_q <= w_raddr_q + AW'(1);
          end
        end
        S_DRAIN: begin
          energy_q       <= energy_d;
          energy_valid_q <= 1'b1;
          state_q        <= S_DONE;
        end
        S_DONE: begin
          if (energy_ready_i) begin
            energy_valid_q <= 1'b0;
            start_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign start_ready_o  = start_ready_q;
  assign w_ren_o        = w_ren_q;
  assign w_raddr_o      = w_raddr_q;
  assign energy_valid_o = energy_valid_q;
  assign energy_o       = energy_q;
  assign busy_o         = busy_q;

endmodule
